// File: rtl/dram_ref_reader.sv
// DRAM reference reader: fetches reference blocks word by word from DRAM, assembles them
// and streams complete blocks to one Smith-Waterman engine through a 2-entry credit-managed FIFO.
module dram_ref_reader #(
    parameter int REF_LENGTH = 128,
    parameter int DRAM_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [24:0]             ref_addr_in,
    input  logic [24:0]             ref_length_in,
    input  logic                    ref_info_valid_in,
    output logic                    busy_out,
    output logic [24:0]             rd_addr_out,
    output logic                    rd_req_out,
    input  logic                    rd_req_rdy_in,
    input  logic [DRAM_WIDTH-1:0]   rd_data_in,
    input  logic                    rd_data_valid_in,
    output logic [2*REF_LENGTH-1:0] ref_seq_block_out,
    output logic                    ref_seq_block_valid_out,
    input  logic                    ref_seq_block_rdy_in,
    output logic                    last_block_out
);

    localparam int BLK_W  = 2 * REF_LENGTH;
    localparam int BEATS  = BLK_W / DRAM_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int WORD_W = 25 + $clog2(BEATS);
    localparam int USED_W = $clog2(2 * BEATS) + 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BEATS - 1);
    localparam logic [USED_W-1:0] CREDIT_MAX = USED_W'(2 * BEATS);
    localparam logic [USED_W-1:0] BLK_WORDS  = USED_W'(BEATS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [24:0]         addr_r;
    logic                req_r, req_nxt_s;
    logic [WORD_W-1:0]   req_left_r, req_left_nxt_s;
    logic [24:0]         blk_left_r;
    logic [USED_W-1:0]   used_r, used_nxt_s;
    logic [BEAT_W-1:0]   beat_r;
    logic [BLK_W-1:0]    asm_r, push_data_s;
    logic [BLK_W-1:0]    ent0_r, ent1_r;
    logic                last0_r, last1_r;
    logic [1:0]          cnt_r, cnt_nxt_s;
    logic                vld_r;
    logic                accept_s, req_hs_s, pop_s, beat_in_s, push_s, push_last_s;

    // Handshake decode and block assembly with the incoming beat merged in
    always_comb begin
        req_hs_s    = req_r && rd_req_rdy_in;
        pop_s       = vld_r && ref_seq_block_rdy_in;
        beat_in_s   = rd_data_valid_in && (state_r != IDLE);
        push_s      = beat_in_s && (beat_r == LAST_BEAT);
        push_last_s = (blk_left_r == 25'd1);
        push_data_s = asm_r;
        for (int k = 0; k < BEATS; k++) begin
            if (beat_r == BEAT_W'(k)) begin
                push_data_s[k*DRAM_WIDTH +: DRAM_WIDTH] = rd_data_in;
            end else begin
                push_data_s[k*DRAM_WIDTH +: DRAM_WIDTH] = asm_r[k*DRAM_WIDTH +: DRAM_WIDTH];
            end
        end
    end

    // Next state, request bookkeeping and credit accounting
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (ref_info_valid_in && (ref_length_in != 25'd0)) begin
                    accept_s    = 1'b1;
                    state_nxt_s = FETCH;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            FETCH: begin
                if (req_hs_s && (req_left_r == WORD_W'(1))) begin
                    state_nxt_s = DRAIN;
                end else begin
                    state_nxt_s = FETCH;
                end
            end
            DRAIN: begin
                if (pop_s && last0_r) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DRAIN;
                end
            end
            default: state_nxt_s = IDLE;
        endcase

        if (accept_s) begin
            req_left_nxt_s = WORD_W'(ref_length_in) * WORD_W'(BEATS);
        end else if (req_hs_s) begin
            req_left_nxt_s = req_left_r - WORD_W'(1);
        end else begin
            req_left_nxt_s = req_left_r;
        end

        // A returning word only moves between in-flight, assembly and FIFO, so the
        // credit total changes solely on a request handshake or a block pop.
        if (req_hs_s && pop_s) begin
            used_nxt_s = used_r + USED_W'(1) - BLK_WORDS;
        end else if (req_hs_s) begin
            used_nxt_s = used_r + USED_W'(1);
        end else if (pop_s) begin
            used_nxt_s = used_r - BLK_WORDS;
        end else begin
            used_nxt_s = used_r;
        end

        req_nxt_s = (state_nxt_s == FETCH) && (req_left_nxt_s != {WORD_W{1'b0}})
                    && (used_nxt_s < CREDIT_MAX);

        case ({push_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + 2'd1;
            2'b01:   cnt_nxt_s = cnt_r - 2'd1;
            default: cnt_nxt_s = cnt_r;
        endcase
    end

    // Control state, request address and counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r    <= IDLE;
            req_r      <= 1'b0;
            addr_r     <= 25'd0;
            req_left_r <= {WORD_W{1'b0}};
            blk_left_r <= 25'd0;
            used_r     <= {USED_W{1'b0}};
            beat_r     <= {BEAT_W{1'b0}};
            asm_r      <= {BLK_W{1'b0}};
        end else begin
            state_r    <= state_nxt_s;
            req_r      <= req_nxt_s;
            req_left_r <= req_left_nxt_s;
            used_r     <= used_nxt_s;
            if (accept_s) begin
                addr_r <= ref_addr_in;
            end else if (req_hs_s) begin
                addr_r <= addr_r + 25'd1;
            end else begin
                addr_r <= addr_r;
            end
            if (accept_s) begin
                blk_left_r <= ref_length_in;
            end else if (push_s) begin
                blk_left_r <= blk_left_r - 25'd1;
            end else begin
                blk_left_r <= blk_left_r;
            end
            if (push_s) begin
                beat_r <= {BEAT_W{1'b0}};
                asm_r  <= {BLK_W{1'b0}};
            end else if (beat_in_s) begin
                beat_r <= beat_r + BEAT_W'(1);
                asm_r  <= push_data_s;
            end else begin
                beat_r <= beat_r;
                asm_r  <= asm_r;
            end
        end
    end

    // Two-entry output FIFO; entry 0 is always the head so the output is a register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ent0_r  <= {BLK_W{1'b0}};
            ent1_r  <= {BLK_W{1'b0}};
            last0_r <= 1'b0;
            last1_r <= 1'b0;
            cnt_r   <= 2'd0;
            vld_r   <= 1'b0;
        end else begin
            cnt_r <= cnt_nxt_s;
            vld_r <= (cnt_nxt_s != 2'd0);
            case ({push_s, pop_s})
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ent0_r  <= push_data_s;
                        last0_r <= push_last_s;
                    end else begin
                        ent1_r  <= push_data_s;
                        last1_r <= push_last_s;
                    end
                end
                2'b01: begin
                    ent0_r  <= ent1_r;
                    last0_r <= last1_r;
                end
                2'b11: begin
                    if (cnt_r == 2'd2) begin
                        ent0_r  <= ent1_r;
                        last0_r <= last1_r;
                        ent1_r  <= push_data_s;
                        last1_r <= push_last_s;
                    end else begin
                        ent0_r  <= push_data_s;
                        last0_r <= push_last_s;
                    end
                end
                default: begin
                    ent0_r  <= ent0_r;
                    last0_r <= last0_r;
                end
            endcase
        end
    end

    assign busy_out                = (state_r != IDLE);
    assign rd_addr_out             = addr_r;
    assign rd_req_out              = req_r;
    assign ref_seq_block_out       = ent0_r;
    assign ref_seq_block_valid_out = vld_r;
    assign last_block_out          = vld_r && last0_r;

endmodule

// File: doc/dram_ref_reader.md
# dram_ref_reader

DRAM reference reader for one Smith-Waterman engine. It accepts a reference descriptor (start address and block count) from the engine controller and issues DRAM word reads. It assembles the returned words into full reference blocks of 2*REF_LENGTH bits and streams those blocks to the engine over a valid/rdy handshake. It is the producer on the engine's reference-sequence port: it consumes `ref_addr/ref_length/ref_info_valid` and drives `ref_seq_block/valid`.

## Interface
Parameters:
- REF_LENGTH, 128, bases per reference block (2 bits per base)
- DRAM_WIDTH, 64, DRAM read data width in bits; must divide 2*REF_LENGTH
- BEATS (localparam), 2*REF_LENGTH/DRAM_WIDTH (4 with the defaults), DRAM words per block

Ports:
- clk  in  1  system clock; everything is rising-edge
- rst  in  1  asynchronous, active-low reset
- ref_addr_in  in  25  DRAM word address of the first word of block 0
- ref_length_in  in  25  number of blocks to read
- ref_info_valid_in  in  1  descriptor valid; sampled only in IDLE
- busy_out  out  1  high from descriptor accept until the last block is handed off
- rd_addr_out  out  25  DRAM read word address
- rd_req_out  out  1  read request valid
- rd_req_rdy_in  in  1  DRAM accepts the request this cycle
- rd_data_in  in  DRAM_WIDTH  read data; returned in request order
- rd_data_valid_in  in  1  read data valid; DRAM cannot be stalled
- ref_seq_block_out  out  2*REF_LENGTH  assembled reference block
- ref_seq_block_valid_out  out  1  block valid
- ref_seq_block_rdy_in  in  1  engine accepts the block
- last_block_out  out  1  qualifies ref_seq_block_out as block ref_length-1

## Operation
- Every output and every internal register resets to 0, and the FSM enters IDLE.
- States:
  - IDLE: if ref_info_valid_in is high and ref_length_in is nonzero, latch addr and length, set the word counter to ref_length*BEATS, go to FETCH. If ref_length_in is 0, ignore the descriptor and stay in IDLE.
  - FETCH: drive rd_req_out when credit is available. On each handshake (rd_req_out && rd_req_rdy_in), rd_addr_out increments by 1 and the request counter decrements. Go to DRAIN when the last word has been requested.
  - DRAIN: no requests. Return to IDLE in the cycle the final block handshakes.
- Descriptors are accepted only in IDLE. ref_info_valid_in is ignored in FETCH and DRAIN, with no queuing.
- Credit flow control:
  - The output block FIFO holds 2 entries (2*BEATS words).
  - Requests are issued only while (words in flight + words in the assembly register + BEATS × FIFO occupancy) < 2*BEATS.
  - Because of this credit rule, the FIFO can never overflow and DRAM data is never dropped.
- Assembly:
  - Beat k of a block (k = 0..BEATS-1) lands in bits [(k+1)*DRAM_WIDTH-1 : k*DRAM_WIDTH], so the first word is least significant.
  - On beat BEATS-1, the block is pushed into the FIFO together with its last flag (set when it is block ref_length-1) and the beat counter wraps to 0.
- rd_data_valid_in is ignored in IDLE.
- Counter widths: the word counter is 25+log2(BEATS) bits. rd_addr_out wraps modulo 2^25.
- busy_out is combinational: (state != IDLE).

## Timing
- A descriptor sampled in IDLE at edge N gives FETCH and busy_out = 1 from cycle N+1. rd_req_out and rd_addr_out are registered: first asserted in cycle N+1 with rd_addr_out = ref_addr_in.
- Request handshake:
  - While rd_req_out is high and rd_req_rdy_in is low, rd_addr_out and rd_req_out hold stable.
  - Back-to-back requests are issued every cycle while credit remains.
- Block output:
  - The final beat of a block, sampled at edge M, gives ref_seq_block_valid_out = 1 in cycle M+1 when the FIFO was empty.
  - The output holds until ref_seq_block_rdy_in is high, then shows the next entry the following cycle.
  - A FIFO push and pop in the same cycle are both performed.
  - Sustained throughput is 1 block per BEATS cycles.
- Transfer completion: on the handshake of the last-flagged block, the FSM is in IDLE and busy_out = 0 the next cycle. A new descriptor is accepted that cycle.
- Reset mid-transfer clears all state asynchronously. The system resets the DRAM controller on the same rst, so no stale data returns.

## Test plan
- Descriptor addr=0x100, length=1; DRAM returns D0..D3 one cycle after each request → requests to 0x100..0x103; one block = {D3,D2,D1,D0}; last_block_out=1; busy_out=0 the cycle after the handshake.
- Descriptor length=3, ref_seq_block_rdy_in held low → exactly 8 requests (0x000..0x007), then rd_req_out=0. Raise rdy → remaining 4 requests; blocks delivered in order; last_block_out set only on block 2.
- rd_req_rdy_in low for 5 cycles mid-FETCH → rd_addr_out and rd_req_out stable throughout; no skipped or duplicated address.
- length=0 descriptor → no rd_req_out; busy_out stays 0. A second descriptor (addr=0x200, length=2) sent while busy → ignored; only the first transfer's addresses appear.
- rst asserted low after 6 of 12 words returned → all outputs 0 immediately. A new descriptor after release reads from its own address, with no leftover partial block.
- Full-rate stream: length=16, rdy_in always 1, DRAM latency 3 → 64 requests; valid_out is high in a 1-of-4 cycle pattern in steady state; every block matches the expected words.
